mem_access_unit: RTL and testbench

Load/store unit for the multicycle RV32 core. Sits directly downstream of the control FSM's memory states: it accepts one load or store request per `start` pulse and runs a req/ack transaction on the shared memory bus. It performs RV32I byte/halfword lane steering with sign/zero extension, and reports completion with a one-cycle `done`, plus `err` on a fault.

---
 rtl/mem_access_unit.sv | 164 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - RV32 load/store unit driving a req/ack memory bus.
// Optional misalignment faults are enabled by defining MEM_ACCESS_MISALIGN_CHECK_EN.
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE, S_FAULT} state_t;

  localparam bit          TMO_EN   = (TIMEOUT != 0);
  localparam logic [15:0] TMO_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] tmo_cnt;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;

  logic        f3_ok;
  logic        misalign;
  logic [3:0]  be_calc;
  logic [31:0] wdata_rep;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  always_comb begin
    f3_ok = 1'b0;
    if (we) f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    else    f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b101);
  end

  always_comb begin
    misalign = 1'b0;
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
    case (funct3[1:0])
      2'b01:   misalign = addr[0];
      2'b10:   misalign = (addr[1:0] != 2'b00);
      default: misalign = 1'b0;
    endcase
`endif
  end

  // Low address bits beyond the access size are ignored when no misalign check is built in.
  always_comb begin
    be_calc   = 4'b1111;
    wdata_rep = wdata;
    case (funct3[1:0])
      2'b00: begin
        be_calc   = 4'b0001 << addr[1:0];
        wdata_rep = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_calc   = addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
      end
      default: begin
        be_calc   = 4'b1111;
        wdata_rep = wdata;
      end
    endcase
  end

  always_comb begin
    byte_sel = mem_rdata[7:0];
    case (lane_q)
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_ext = {24'd0, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_ext = {16'd0, half_sel};
      default: load_ext = mem_rdata;
    endcase
  end

  // Outputs are registered on the transition into each state so they stay glitch-free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      tmo_cnt   <= 16'd0;
      f3_q      <= 3'd0;
      lane_q    <= 2'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata     <= 32'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_be    <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (!f3_ok || misalign) begin
              state <= S_FAULT;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state     <= S_BUS;
              tmo_cnt   <= 16'd0;
              f3_q      <= funct3;
              lane_q    <= addr[1:0];
              mem_req   <= 1'b1;
              mem_we    <= we;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_wdata <= wdata_rep;
              mem_be    <= be_calc;
            end
          end
        end
        S_BUS: begin
          if (mem_ack) begin
            if (!mem_we) rdata <= load_ext;
            state   <= S_DONE;
            mem_req <= 1'b0;
            done    <= 1'b1;
          end else if (TMO_EN && (tmo_cnt == TMO_LAST)) begin
            state   <= S_FAULT;
            mem_req <= 1'b0;
            done    <= 1'b1;
            err     <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        S_DONE, S_FAULT: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          err   <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit (TIMEOUT=4).
module tb_mem_access_unit;

  typedef struct {logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata;} bus_t;
  typedef struct {logic err; logic [31:0] rdata;} rsp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        busy, done, err, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ack = 1'b0;

  int checks = 0;
  int errors = 0;
  bus_t bus_q[$];
  rsp_t rsp_q[$];
  bus_t bexp;
  rsp_t rexp;
  logic prev_req = 1'b0;

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .start(start), .we(we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
    .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      prev_req = 1'b0;
    end else begin
      if (mem_req && !prev_req) begin
        checks++;
        if (bus_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_req actual=addr %h expected=no request", mem_addr);
        end else begin
          bexp = bus_q.pop_front();
          if (mem_we !== bexp.we || mem_addr !== bexp.addr || mem_be !== bexp.be ||
              (bexp.we && mem_wdata !== bexp.wdata)) begin
            errors++;
            $display("FAIL bus_fields actual=we %b addr %h be %b wdata %h expected=we %b addr %h be %b wdata %h",
                     mem_we, mem_addr, mem_be, mem_wdata, bexp.we, bexp.addr, bexp.be, bexp.wdata);
          end
        end
      end
      prev_req = mem_req;
      if (done) begin
        checks++;
        if (rsp_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_done actual=done 1 expected=no done");
        end else begin
          rexp = rsp_q.pop_front();
          if (err !== rexp.err || rdata !== rexp.rdata) begin
            errors++;
            $display("FAIL response actual=err %b rdata %h expected=err %b rdata %h",
                     err, rdata, rexp.err, rexp.rdata);
          end
        end
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    chk("return_idle", 32'(busy), 32'd0);
  endtask

  task automatic run_op(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input int d,
                        input logic bus_on, input logic [31:0] e_addr, input logic [3:0] e_be,
                        input logic [31:0] e_wdata, input logic e_err, input logic [31:0] e_rdata);
    if (bus_on) bus_q.push_back('{w, e_addr, e_be, e_wdata});
    rsp_q.push_back('{e_err, e_rdata});
    @(negedge clk);
    we = w; funct3 = f3; addr = a; wdata = wd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (!bus_on) begin
      chk("fault_cycle1", {29'd0, done, err, mem_req}, 32'd6);
    end else begin
      repeat (d) @(negedge clk);
      mem_rdata = rd; mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = 32'h0BAD0BAD;
      chk("done_after_ack", 32'(done), 32'd1);
    end
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #12;
    chk("rst_ctrl", {26'd0, busy, done, err, mem_req, mem_we, 1'b0}, 32'd0);
    chk("rst_be", {28'd0, mem_be}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);

    run_op(0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 3, 1, 32'h100, 4'b1111, 0, 0, 32'hDEADBEEF);
    run_op(0, 3'b000, 32'h103, 0, 32'h80123456, 1, 1, 32'h100, 4'b1000, 0, 0, 32'hFFFFFF80);
    run_op(0, 3'b100, 32'h103, 0, 32'h80123456, 0, 1, 32'h100, 4'b1000, 0, 0, 32'h00000080);
    run_op(1, 3'b001, 32'h202, 32'h1234ABCD, 0, 2, 1, 32'h200, 4'b1100, 32'hABCDABCD, 0, 32'h00000080);
    if (MIS_EN)
      run_op(0, 3'b010, 32'h102, 0, 32'h13572468, 0, 0, 0, 0, 0, 1, 32'h00000080);
    else
      run_op(0, 3'b010, 32'h102, 0, 32'h13572468, 0, 1, 32'h100, 4'b1111, 0, 0, 32'h13572468);
    run_op(0, 3'b001, 32'h102, 0, 32'h80123456, 0, 1, 32'h100, 4'b1100, 0, 0, 32'hFFFF8012);
    run_op(0, 3'b101, 32'h100, 0, 32'h80128456, 1, 1, 32'h100, 4'b0011, 0, 0, 32'h00008456);
    run_op(0, 3'b011, 32'h100, 0, 0, 0, 0, 0, 0, 0, 1, 32'h00008456);
    run_op(0, 3'b110, 32'h100, 0, 0, 0, 0, 0, 0, 0, 1, 32'h00008456);
    run_op(1, 3'b011, 32'h100, 0, 0, 0, 0, 0, 0, 0, 1, 32'h00008456);
    run_op(1, 3'b100, 32'h100, 0, 0, 0, 0, 0, 0, 0, 1, 32'h00008456);
    run_op(1, 3'b000, 32'h101, 32'h000000A5, 0, 0, 1, 32'h100, 4'b0010, 32'hA5A5A5A5, 0, 32'h00008456);
    run_op(1, 3'b010, 32'h300, 32'hCAFEF00D, 0, 0, 1, 32'h300, 4'b1111, 32'hCAFEF00D, 0, 32'h00008456);
    run_op(0, 3'b000, 32'h102, 0, 32'h00450000, 0, 1, 32'h100, 4'b0100, 0, 0, 32'h00000045);

    bus_q.push_back('{1'b0, 32'h100, 4'b1111, 32'd0});
    rsp_q.push_back('{1'b1, 32'h00000045});
    @(negedge clk);
    we = 0; funct3 = 3'b010; addr = 32'h100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (mem_req && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("timeout_req_cycles", 32'(n), 32'd4);
    chk("timeout_done_err", {30'd0, done, err}, 32'd3);
    wait_idle();
    run_op(0, 3'b010, 32'h104, 0, 32'h55AA55AA, 0, 1, 32'h104, 4'b1111, 0, 0, 32'h55AA55AA);

    bus_q.push_back('{1'b0, 32'h108, 4'b1111, 32'd0});
    rsp_q.push_back('{1'b0, 32'h00001111});
    @(negedge clk);
    we = 0; funct3 = 3'b010; addr = 32'h108; start = 1'b1;
    @(negedge clk);
    we = 1; addr = 32'h400; wdata = 32'hFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0; mem_rdata = 32'h00001111; mem_ack = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (done) n++;
    end
    chk("single_done", 32'(n), 32'd1);

    bus_q.push_back('{1'b0, 32'h10C, 4'b1111, 32'd0});
    @(negedge clk);
    we = 0; funct3 = 3'b010; addr = 32'h10C; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_ctrl", {29'd0, mem_req, busy, done}, 32'd0);
    chk("rst_mid_rdata", rdata, 32'd0);
    @(negedge clk); reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_mid_idle", {30'd0, busy, mem_req}, 32'd0);
    chk("queues_empty", 32'(bus_q.size() + rsp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
